// File: rtl/amba_pkg.sv
// Shared AXI-lite definitions for the memory slave and its master: response codes,
// channel FSM encodings and the address-decode helper.
package amba_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  // Word-aligned, at or above base, and inside the array.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] words);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && ((offset >> 2) < words) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/amba_slave_ram.sv
// Word memory built from four byte lanes: one byte-enabled write port and one
// registered read port that returns pre-write data on a same-edge collision.
module amba_slave_ram #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (we && be[gi]) lane_mem[waddr] <= wdata[8*gi +: 8];
      if (re) lane_q <= lane_mem[raddr];
    end

    assign rdata[8*gi +: 8] = lane_q;
  end

endmodule

// File: rtl/amba_memory_slave.sv
// AXI-lite memory slave with independent write and read FSMs over one shared RAM.
// Define AMBA_SLAVE_WSTRB_EN to honour WSTRB byte lanes; otherwise writes are full-word.
module amba_memory_slave
  import amba_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        reset,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic       awready_q, awready_d;
  logic       wready_q,  wready_d;
  logic       bvalid_q,  bvalid_d;
  logic [1:0] bresp_q,   bresp_d;
  logic       arready_q, arready_d;
  logic       rvalid_q,  rvalid_d;
  logic [1:0] rresp_q,   rresp_d;
  logic       rd_ok_q,   rd_ok_d;

  logic          wr_ok, rd_ok;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [3:0]    wr_be;
  logic          ram_we, ram_re;
  logic [31:0]   ram_rdata;
  logic          unused_in;

  assign wr_ok  = addr_in_range(AWADDR, BASE_ADDR, 32'(MEM_WORDS));
  assign rd_ok  = addr_in_range(ARADDR, BASE_ADDR, 32'(MEM_WORDS));
  assign wr_idx = AW'((AWADDR - BASE_ADDR) >> 2);
  assign rd_idx = AW'((ARADDR - BASE_ADDR) >> 2);

`ifdef AMBA_SLAVE_WSTRB_EN
  assign wr_be     = WSTRB;
  assign unused_in = ^{AWPROT, ARPROT};
`else
  assign wr_be     = 4'hF;
  assign unused_in = ^{AWPROT, ARPROT, WSTRB};
`endif

  // Commit happens on the edge that closes W_ACK; out-of-range never reaches the RAM.
  assign ram_we = (w_state_q == W_ACK) && wr_ok;
  assign ram_re = (r_state_q == R_ACK);

  amba_slave_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (ACLK),
    .we    (ram_we),
    .be    (wr_be),
    .waddr (wr_idx),
    .wdata (WDATA),
    .re    (ram_re),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID && WVALID) begin
          w_state_d = W_ACK;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      W_ACK: begin
        w_state_d = W_RESP;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b1;
        bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rd_ok_d   = rd_ok_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          r_state_d = R_ACK;
          arready_d = 1'b1;
        end
      end
      R_ACK: begin
        r_state_d = R_DATA;
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
        rd_ok_d   = rd_ok;
      end
      R_DATA: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rd_ok_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  // RAM output register is un-reset, so gate it with a reset flop for zero-on-reset/error.
  assign RDATA   = rd_ok_q ? ram_rdata : 32'h0;

endmodule
